// File: rtl/blockmem_arbiter.sv
// blockmem_arbiter: two-port round-robin arbiter and fixed-latency access
// sequencer in front of the block-organised data memory.
// Port 0 = instruction-cache refill (block read only),
// port 1 = data cache (block read or single-word write).
// Optional build macro: BLOCKMEM_ARB_STATS_EN adds per-port wait-cycle counters.
module blockmem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3,
    parameter int LATENCY       = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     p0_req,
    input  logic [ADDRESS_WIDTH-1:0]                 p0_addr,
    output logic                                     p0_ready,
    output logic [(2**BLOCK_SIZE)*DATA_WIDTH-1:0]    p0_block,
    input  logic                                     p1_req,
    input  logic                                     p1_we,
    input  logic [ADDRESS_WIDTH-1:0]                 p1_addr,
    input  logic [DATA_WIDTH-1:0]                    p1_wdata,
    output logic                                     p1_ready,
    output logic [(2**BLOCK_SIZE)*DATA_WIDTH-1:0]    p1_block,
    output logic [ADDRESS_WIDTH-1:0]                 mem_address,
    output logic [DATA_WIDTH-1:0]                    mem_write_data,
    output logic                                     mem_write_enable,
    input  logic [(2**BLOCK_SIZE)*DATA_WIDTH-1:0]    mem_read_data
`ifdef BLOCKMEM_ARB_STATS_EN
    ,
    output logic [31:0]                              p0_wait_cycles,
    output logic [31:0]                              p1_wait_cycles
`endif
);

    localparam int BW = (2**BLOCK_SIZE) * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     grant_q, grant_d;
    logic                     last_grant_q, last_grant_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [BW-1:0]            p0_block_q, p0_block_d;
    logic [BW-1:0]            p1_block_q, p1_block_d;

    logic anyReq;
    logic grantNow;
    logic busy;

    // Round-robin choice: a lone requester wins; on a tie the port that was not granted last wins.
    always_comb begin
        anyReq   = p0_req | p1_req;
        grantNow = (p0_req & p1_req) ? ~last_grant_q : p1_req;
    end

    // Next-state logic: grant and latch in IDLE, count wait states in ACCESS, one-cycle response in RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        p0_block_d   = p0_block_q;
        p1_block_d   = p1_block_q;
        unique case (state_q)
            IDLE: begin
                if (anyReq) begin
                    grant_d      = grantNow;
                    last_grant_d = grantNow;
                    addr_d       = grantNow ? p1_addr : p0_addr;
                    we_d         = grantNow & p1_we;
                    wdata_d      = grantNow ? p1_wdata : '0;
                    cnt_d        = 8'(LATENCY - 1);
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    if (grant_q) begin
                        p1_block_d = mem_read_data;
                    end else begin
                        p0_block_d = mem_read_data;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            p0_block_q   <= '0;
            p1_block_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            p0_block_q   <= p0_block_d;
            p1_block_q   <= p1_block_d;
        end
    end

    // Memory-side and response outputs decode purely from registered state, so reset clears them at once.
    always_comb begin
        busy             = (state_q != IDLE);
        mem_address      = busy ? addr_q : '0;
        mem_write_data   = busy ? wdata_q : '0;
        mem_write_enable = (state_q == ACCESS) && (cnt_q == 8'd0) && we_q;
        p0_ready         = (state_q == RESP) && !grant_q;
        p1_ready         = (state_q == RESP) && grant_q;
        p0_block         = p0_block_q;
        p1_block         = p1_block_q;
    end

`ifdef BLOCKMEM_ARB_STATS_EN
    logic        p0Waiting, p1Waiting;
    logic [31:0] p0_wait_q, p1_wait_q;

    // A port is waiting when it requests but is neither being served nor being granted this cycle.
    always_comb begin
        p0Waiting = p0_req && !(busy && !grant_q) && !(!busy && !grantNow);
        p1Waiting = p1_req && !(busy && grant_q) && !(!busy && grantNow);
    end

    // Saturating wait-cycle counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_wait_q <= '0;
            p1_wait_q <= '0;
        end else begin
            if (p0Waiting && (p0_wait_q != 32'hFFFF_FFFF)) begin
                p0_wait_q <= p0_wait_q + 32'd1;
            end
            if (p1Waiting && (p1_wait_q != 32'hFFFF_FFFF)) begin
                p1_wait_q <= p1_wait_q + 32'd1;
            end
        end
    end

    assign p0_wait_cycles = p0_wait_q;
    assign p1_wait_cycles = p1_wait_q;
`endif

endmodule
